// File: rtl/spi_sd_pkg.sv
// Shared SPI SD controller definitions: lane width, RX word-buffer size limit
// and the CPU read-command encoding used by the RX word buffer and the CPU
// register decoder.
package spi_sd_pkg;

    localparam int SD_LANE_W         = 8;
    localparam int RX_WBUF_BYTES_MAX = 4;

    // CPU read command presented to the RX word buffer
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BYTE = 2'd1,
        RD_WORD = 2'd2
    } rd_cmd_e;

    // Collapse the two read strobes into one command; a byte read takes
    // precedence over a simultaneous word read.
    function automatic rd_cmd_e rd_cmd_decode(input logic rd_byte, input logic rd_word);
        if (rd_byte) begin
            return RD_BYTE;
        end
        if (rd_word) begin
            return RD_WORD;
        end
        return RD_NONE;
    endfunction

endpackage

// File: rtl/rx_cpu_wbuf.sv
// RX CPU word buffer: assembles bytes popped from the RX byte FIFO into a
// BYTES-lane word. The CPU either shifts out the oldest byte or takes the whole
// word. Provides a fill level and a sticky misuse flag.
// Optional build macro RX_CPU_WBUF_BSWAP_EN adds a bswap input that presents
// q with lane 0 in the LSBs (little-endian CPU view).
module rx_cpu_wbuf
    import spi_sd_pkg::*;
#(
    parameter int BYTES  = 2,
    parameter int LANE_W = SD_LANE_W,
    parameter int CW     = $clog2(BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rd_byte,
    input  logic                    rd_word,
    input  logic                    clr_err,
`ifdef RX_CPU_WBUF_BSWAP_EN
    input  logic                    bswap,
`endif
    input  logic                    fifo_has_data,
    input  logic [LANE_W-1:0]       fifo_data,
    output logic                    fifo_pop,
    output logic [BYTES*LANE_W-1:0] q,
    output logic [CW-1:0]           level,
    output logic                    empty,
    output logic                    full,
    output logic                    err
);

    localparam int            QW       = BYTES * LANE_W;
    localparam logic [CW-1:0] LVL_FULL = CW'(BYTES);

    rd_cmd_e       rd_cmd;
    logic          byte_ok;
    logic          pop_int;
    logic          err_set;
    logic [CW-1:0] level_post;
    // Lane k lives at bits [(BYTES-1-k)*LANE_W +: LANE_W], so lane 0 is in the
    // MSBs and a byte read is a plain left shift of the whole image.
    logic [QW-1:0] lanes;
    logic [QW-1:0] lanes_nxt;

    // Decode the read, derive the post-read level and the pop/error decisions
    always_comb begin
        rd_cmd     = rd_cmd_decode(rd_byte, rd_word);
        byte_ok    = (rd_cmd == RD_BYTE) && (level != '0);
        level_post = byte_ok ? (level - CW'(1)) : level;
        pop_int    = fifo_has_data && (rd_cmd != RD_WORD) && (level_post < LVL_FULL);
        err_set    = ((rd_cmd == RD_BYTE) && (level == '0)) ||
                     ((rd_cmd == RD_WORD) && (level != LVL_FULL));
    end

    // The FIFO must never see a pop while the buffer is held in reset
    assign fifo_pop = pop_int && reset_n;

    // Next lane image: shift out the oldest byte, then land the popped byte
    // just above the remaining valid lanes
    always_comb begin
        // NOTE: combinational blocks take a full default first so no path
        // leaves lanes_nxt unassigned and no latch is inferred.
        lanes_nxt = byte_ok ? (lanes << LANE_W) : lanes;
        for (int i = 0; i < BYTES; i++) begin
            if (pop_int && (level_post == CW'(i))) begin
                lanes_nxt[(BYTES-1-i)*LANE_W +: LANE_W] = fifo_data;
            end
        end
    end

    // Lane storage
    // NOTE: data lanes carry no reset; level alone defines which lanes are
    // valid, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        lanes <= lanes_nxt;
    end

    // Fill level and sticky misuse flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            err   <= 1'b0;
        end else begin
            if (rd_cmd == RD_WORD) begin
                level <= '0;
            end else begin
                level <= level_post + CW'(pop_int);
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // Present the lanes on q, optionally byte-reversed for a little-endian view
    for (genvar g = 0; g < BYTES; g++) begin : g_q
`ifdef RX_CPU_WBUF_BSWAP_EN
        assign q[(BYTES-1-g)*LANE_W +: LANE_W] = bswap ? lanes[g*LANE_W +: LANE_W]
                                                       : lanes[(BYTES-1-g)*LANE_W +: LANE_W];
`else
        assign q[(BYTES-1-g)*LANE_W +: LANE_W] = lanes[(BYTES-1-g)*LANE_W +: LANE_W];
`endif
    end

endmodule

// File: tb/tb_rx_cpu_wbuf.sv
// Self-checking bench for rx_cpu_wbuf. Two instances (BYTES=2 and BYTES=4)
// share clock and reset; a queue-per-instance model predicts fifo_pop, level,
// flags, err and the valid lanes of q.
module tb_rx_cpu_wbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rd_byte_s [2];
    logic       rd_word_s [2];
    logic       clr_err_s [2];
    logic       has_s     [2];
    logic [7:0] data_s    [2];

    logic        pop2, pop4;
    logic [15:0] q2;
    logic [31:0] q4;
    logic [1:0]  level2;
    logic [2:0]  level4;
    logic        empty2, full2, err2;
    logic        empty4, full4, err4;
`ifdef RX_CPU_WBUF_BSWAP_EN
    logic        bswap2, bswap4;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: valid bytes oldest-first, plus the sticky error bit
    logic [7:0] mq [2][$];
    bit         merr [2];
    int         nb [2] = '{2, 4};

    rx_cpu_wbuf #(.BYTES(2)) u_dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_byte       (rd_byte_s[0]),
        .rd_word       (rd_word_s[0]),
        .clr_err       (clr_err_s[0]),
`ifdef RX_CPU_WBUF_BSWAP_EN
        .bswap         (bswap2),
`endif
        .fifo_has_data (has_s[0]),
        .fifo_data     (data_s[0]),
        .fifo_pop      (pop2),
        .q             (q2),
        .level         (level2),
        .empty         (empty2),
        .full          (full2),
        .err           (err2)
    );

    rx_cpu_wbuf #(.BYTES(4)) u_dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_byte       (rd_byte_s[1]),
        .rd_word       (rd_word_s[1]),
        .clr_err       (clr_err_s[1]),
`ifdef RX_CPU_WBUF_BSWAP_EN
        .bswap         (bswap4),
`endif
        .fifo_has_data (has_s[1]),
        .fifo_data     (data_s[1]),
        .fifo_pop      (pop4),
        .q             (q4),
        .level         (level4),
        .empty         (empty4),
        .full          (full4),
        .err           (err4)
    );

    function automatic logic obs_pop(input int id);
        return (id == 0) ? pop2 : pop4;
    endfunction

    function automatic logic [3:0] obs_level(input int id);
        return (id == 0) ? {2'b00, level2} : {1'b0, level4};
    endfunction

    function automatic logic [2:0] obs_flags(input int id);
        return (id == 0) ? {empty2, full2, err2} : {empty4, full4, err4};
    endfunction

    function automatic logic [31:0] obs_q(input int id);
        return (id == 0) ? {16'h0000, q2} : q4;
    endfunction

    // Compare every observable output of one instance against the model
    task automatic check_state(input int id, input string tag);
        int          n;
        int          pos;
        logic [31:0] expq;
        logic [31:0] mask;
        logic [3:0]  exp_lvl;
        logic [2:0]  exp_flags;
        n    = mq[id].size();
        expq = '0;
        mask = '0;
        for (int k = 0; k < n; k++) begin
            pos              = (nb[id] - 1 - k) * 8;
            expq[pos +: 8]   = mq[id][k];
            mask[pos +: 8]   = 8'hFF;
        end
        exp_lvl   = 4'(n);
        exp_flags = {n == 0, n == nb[id], merr[id]};
        checks++;
        if (obs_level(id) !== exp_lvl) begin
            errors++;
            $display("FAIL %s.level dut%0d got %0d want %0d", tag, nb[id], obs_level(id), exp_lvl);
        end
        checks++;
        if (obs_flags(id) !== exp_flags) begin
            errors++;
            $display("FAIL %s.empty_full_err dut%0d got %b want %b", tag, nb[id], obs_flags(id), exp_flags);
        end
        checks++;
        if ((obs_q(id) & mask) !== expq) begin
            errors++;
            $display("FAIL %s.q dut%0d got %h want %h (mask %h)", tag, nb[id], obs_q(id) & mask, expq, mask);
        end
    endtask

    // One clock cycle on one instance: drive after a falling edge, check the
    // same-cycle pop, clock, advance the model, check state at the next fall
    task automatic run_cycle(input int id, input bit rb, input bit rw, input bit ce,
                             input bit has, input logic [7:0] d, input string tag);
        int   post;
        bit   set_err;
        logic exp_pop;
        rd_byte_s[id] = rb;
        rd_word_s[id] = rw;
        clr_err_s[id] = ce;
        has_s[id]     = has;
        data_s[id]    = d;
        post    = mq[id].size();
        set_err = 1'b0;
        if (rb) begin
            if (post > 0) post--; else set_err = 1'b1;
        end else if (rw) begin
            if (post != nb[id]) set_err = 1'b1;
        end
        exp_pop = has && !(rw && !rb) && (post < nb[id]);
        #1;
        checks++;
        if (obs_pop(id) !== exp_pop) begin
            errors++;
            $display("FAIL %s.fifo_pop dut%0d got %b want %b", tag, nb[id], obs_pop(id), exp_pop);
        end
        @(posedge clk);
        if (rb) begin
            if (mq[id].size() > 0) void'(mq[id].pop_front());
        end else if (rw) begin
            mq[id].delete();
        end
        if (exp_pop) mq[id].push_back(d);
        if (set_err) merr[id] = 1'b1;
        else if (ce) merr[id] = 1'b0;
        @(negedge clk);
        rd_byte_s[id] = 1'b0;
        rd_word_s[id] = 1'b0;
        clr_err_s[id] = 1'b0;
        has_s[id]     = 1'b0;
        check_state(id, tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_byte_s[i] = 1'b0;
            rd_word_s[i] = 1'b0;
            clr_err_s[i] = 1'b0;
            has_s[i]     = 1'b1;
            data_s[i]    = 8'h99;
            merr[i]      = 1'b0;
            mq[i].delete();
        end
        #1;
        checks++;
        if ({pop2, pop4} !== 2'b00) begin
            errors++;
            $display("FAIL reset.fifo_pop got %b want 00", {pop2, pop4});
        end
        check_state(0, "reset");
        check_state(1, "reset");
        @(negedge clk);
        reset_n  = 1'b1;
        has_s[0] = 1'b0;
        has_s[1] = 1'b0;
    endtask

    task automatic test_fill();
        run_cycle(0, 0, 0, 0, 1, 8'hA5, "fill1");
        run_cycle(0, 0, 0, 0, 1, 8'h3C, "fill2");
        checks++;
        if (q2 !== 16'hA53C) begin
            errors++;
            $display("FAIL fill.q got %h want a53c", q2);
        end
        run_cycle(0, 0, 0, 0, 1, 8'hA5, "fill_full");
        checks++;
        if ({level2, err2} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL fill.level_err got %0d/%b want 2/0", level2, err2);
        end
    endtask

    task automatic test_both_reads();
        run_cycle(0, 0, 1, 0, 0, 8'h00, "drain");
        run_cycle(0, 0, 0, 0, 1, 8'h12, "both_fill1");
        run_cycle(0, 0, 0, 0, 1, 8'h34, "both_fill2");
        run_cycle(0, 1, 1, 0, 0, 8'h00, "both_rd");
        checks++;
        if ({level2, q2[15:8], err2} !== {2'd1, 8'h34, 1'b0}) begin
            errors++;
            $display("FAIL both_rd.direct got lvl %0d q %h err %b want 1 34 0", level2, q2[15:8], err2);
        end
    endtask

    task automatic test_word();
        logic [7:0] fill_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) run_cycle(1, 0, 0, 0, 1, fill_bytes[i], "word_fill");
        checks++;
        if (q4 !== 32'h11223344) begin
            errors++;
            $display("FAIL word_fill.q got %h want 11223344", q4);
        end
        run_cycle(1, 1, 0, 0, 1, 8'h55, "replace");
        checks++;
        if ({q4, level4} !== {32'h22334455, 3'd4}) begin
            errors++;
            $display("FAIL replace.direct got %h/%0d want 22334455/4", q4, level4);
        end
        run_cycle(1, 0, 1, 0, 0, 8'h00, "word_full");
        run_cycle(1, 0, 0, 0, 1, 8'hAA, "part1");
        run_cycle(1, 0, 0, 0, 1, 8'hBB, "part2");
        run_cycle(1, 0, 1, 0, 1, 8'hCC, "word_partial");
        checks++;
        if ({level4, err4} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL word_partial.direct got %0d/%b want 0/1", level4, err4);
        end
        run_cycle(1, 0, 0, 1, 0, 8'h00, "clr_err");
        checks++;
        if (err4 !== 1'b0) begin
            errors++;
            $display("FAIL clr_err.direct got %b want 0", err4);
        end
    endtask

    task automatic test_underflow_reset();
        run_cycle(0, 1, 0, 0, 0, 8'h00, "empty_out");
        run_cycle(0, 1, 0, 0, 1, 8'h7E, "underflow");
        checks++;
        if ({err2, level2, q2[15:8]} !== {1'b1, 2'd1, 8'h7E}) begin
            errors++;
            $display("FAIL underflow.direct got err %b lvl %0d q %h want 1 1 7e", err2, level2, q2[15:8]);
        end
        has_s[0]  = 1'b1;
        data_s[0] = 8'h42;
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            merr[i] = 1'b0;
        end
        #1;
        checks++;
        if (pop2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset.fifo_pop got %b want 0", pop2);
        end
        check_state(0, "async_reset");
        check_state(1, "async_reset");
        @(negedge clk);
        reset_n  = 1'b1;
        has_s[0] = 1'b0;
    endtask

    task automatic test_random();
        int id;
        int r;
        for (int n = 0; n < 400; n++) begin
            id = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 99));
            run_cycle(id, r < 35, (r >= 30) && (r < 45), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) != 0, 8'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_cycle(1, 0, 1, 0, 0, 8'h00, "b2b_drain");
        run_cycle(1, 0, 0, 1, 0, 8'h00, "b2b_clr");
        for (int i = 0; i < 4; i++) run_cycle(1, 0, 0, 0, 1, 8'($urandom), "b2b_fill");
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 1, 0, 0, 1, 8'($urandom), "b2b_stream");
            checks++;
            if (level4 !== 3'd4) begin
                errors++;
                $display("FAIL b2b.level got %0d want 4", level4);
            end
        end
    endtask

`ifdef RX_CPU_WBUF_BSWAP_EN
    task automatic test_bswap();
        logic [7:0] fill_bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_cycle(1, 0, 1, 0, 0, 8'h00, "bs_drain");
        for (int i = 0; i < 4; i++) run_cycle(1, 0, 0, 0, 1, fill_bytes[i], "bs_fill");
        bswap4 = 1'b1;
        #1;
        checks++;
        if (q4 !== 32'h04030201) begin
            errors++;
            $display("FAIL bswap1.q got %h want 04030201", q4);
        end
        bswap4 = 1'b0;
        #1;
        checks++;
        if ({q4, level4} !== {32'h01020304, 3'd4}) begin
            errors++;
            $display("FAIL bswap0.q_level got %h/%0d want 01020304/4", q4, level4);
        end
    endtask
`endif

    initial begin
`ifdef RX_CPU_WBUF_BSWAP_EN
        bswap2 = 1'b0;
        bswap4 = 1'b0;
`endif
        test_reset();
        test_fill();
        test_both_reads();
        test_word();
        test_underflow_reset();
        test_random();
        test_back_to_back();
`ifdef RX_CPU_WBUF_BSWAP_EN
        test_bswap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cpu_wbuf.md
Name: rx_cpu_wbuf

Overview:
Parametrised successor to the SPI SD controller's 2-byte RX CPU staging buffer. Assembles bytes popped from the RX byte FIFO into a CPU-readable word of BYTES lanes. Supports byte reads (shift-out, oldest first) and whole-word reads. Adds an explicit FIFO pop handshake, a fill-level output, and a sticky misuse flag.

Parameters:
BYTES, 2, lanes per CPU word; legal range 2..4
LANE_W, 8, bits per lane; matches the FIFO data width
CW, $clog2(BYTES+1), width of the level count; derived, do not override

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rd_byte  in  1  CPU consumes the oldest lane (1-cycle pulse)
rd_word  in  1  CPU consumes the whole word (1-cycle pulse)
clr_err  in  1  clears the sticky error flag
fifo_has_data  in  1  RX FIFO has a byte on fifo_data
fifo_data  in  LANE_W  head byte of the RX FIFO
fifo_pop  out  1  combinational; pops the FIFO head this cycle
q  out  BYTES*LANE_W  lane 0 (oldest byte) in the MSBs
level  out  CW  number of valid lanes, 0..BYTES
empty  out  1  level==0
full  out  1  level==BYTES
err  out  1  sticky misuse flag

Behaviour:
- Storage:
  - Lane registers b[0..BYTES-1]; b[0] is the oldest byte.
  - Valid lanes are always contiguous from lane 0.
  - Lanes at index >= level are stale and don't-care.
- Reset (asynchronous, active-low):
  - level=0, err=0, hence empty=1 and full=0.
  - Lane contents are not reset.
  - fifo_pop=0 while reset_n=0.
  - Reset during a read pulse discards the read; no partial state remains.
- Priority when both read pulses are asserted: rd_byte wins, rd_word is ignored. This is not an error.
- rd_byte with level>0:
  - b[i] <= b[i+1] for i=0..level-2.
  - Fill is evaluated against post-shift level L' = level-1.
- rd_byte with level==0:
  - err<=1.
  - Otherwise treated as idle, so fill still proceeds.
- rd_word:
  - level <= 0.
  - fifo_pop=0 in that cycle; no fill.
  - If level != BYTES, err<=1. A partial word is still discarded.
- Idle (no read): L' = level.
- Fill:
  - fifo_pop = fifo_has_data && !rd_word_effective && L' < BYTES.
  - On pop: b[L'] <= fifo_data and level <= L'+1; otherwise level <= L'.
  - At most one byte is accepted per cycle.
  - A byte popped in cycle N is visible on q/level in cycle N+1.
- Full and read together: rd_byte while full with fifo_has_data=1 pops a replacement in the same cycle; level stays BYTES.
- err:
  - Sets per the rules above.
  - clr_err clears it; a set in the same cycle wins over the clear.
- Throughput: sustained rd_byte every cycle with a non-empty FIFO keeps level constant, with no bubble.
- fifo_pop depends combinationally on rd_byte, rd_word and fifo_has_data only; there is no path from fifo_data.

Optional Feature:
Macro RX_CPU_WBUF_BSWAP_EN.
- Defined:
  - Adds input port bswap (1 bit).
  - When bswap=1, q presents lanes reversed: lane 0 in the LSBs. This gives a little-endian CPU view of the word.
  - bswap affects only the q ordering. Fill and read semantics are unchanged, and bswap may change on any cycle.
- Undefined:
  - The port is absent.
  - q is always lane 0 in the MSBs (big-endian, SD data order).

Decomposition:
- Shared package spi_sd_pkg, containing:
  - SD_LANE_W = 8
  - RX_WBUF_BYTES_MAX = 4
  - an enum for the read-command encoding {RD_NONE, RD_BYTE, RD_WORD}, reused by the CPU register decoder
- No sub-module. The lane shift/fill is a single always block, and the q ordering is a generate loop. A separate module would only add port noise.

Test Plan:
- Reset, then BYTES=2 with FIFO supplying 0xA5,0x3C continuously: level 0->1->2; q=0xA53C; fifo_pop deasserts once full; err=0.
- BYTES=4, full with 0x11223344, rd_byte with FIFO head 0x55: same-cycle pop; next cycle q=0x22334455, level=4.
- BYTES=4, level=2 (0xAABB....), rd_word: level=0, err=1, fifo_pop=0 that cycle; clr_err next cycle -> err=0.
- BYTES=2, rd_byte and rd_word together while full 0x1234, FIFO empty: byte path taken; level=1, q[15:8]=0x34, err=0.
- rd_byte at level=0 with FIFO head 0x7E: err=1, pop occurs, next cycle level=1, q[15:8]=0x7E. Then assert reset_n=0 mid-stream: level=0 and err=0 immediately, without a clock edge.
- With RX_CPU_WBUF_BSWAP_EN, BYTES=4, full 0x01020304: bswap=1 -> q=0x04030201; toggle bswap=0 -> q=0x01020304; level unchanged.
